ef_uart_rx_fifo: RTL and testbench
==================================

Name: ef_uart_rx_fifo

Overview:
Parametrised UART receive engine with an integrated receive FIFO. It is the next-generation RX path behind the APB UART wrapper. It generalises the fixed 8N1 / 8x-oversampled receiver along these axes:
- data width up to MDW
- samples per bit (SC)
- FIFO depth
- full parity mode set (none/odd/even/stick)
It adds majority-vote sampling, a glitch filter, break detection, an idle timeout, and level/threshold status for interrupt generation by the bus wrapper.

Parameters:
MDW, 9, maximum data bits per frame (runtime data_size is 5..MDW)
SC, 8, baud-tick samples per bit; even, >= 4
FIFO_AW, 4, FIFO address width; depth = 2**FIFO_AW entries of MDW bits
GFLEN, 3, glitch-filter length in PCLK cycles (majority of GFLEN)

Ports:
PCLK  in  1  clock
PRESETn  in  1  asynchronous active-low reset
en  in  1  receiver enable
rx  in  1  serial input (asynchronous)
prescaler  in  16  sample tick every prescaler+1 PCLK cycles
data_size  in  4  data bits per frame, 5..MDW; out-of-range values are treated as MDW
parity_type  in  3  000 none, 001 odd, 010 even, 100 stick-0, 101 stick-1; others treated as none
glitch_filter_en  in  1  enable rx glitch filter
timeout_bits  in  6  idle timeout in bit times; 0 disables
rd  in  1  pop FIFO head
flush  in  1  clear FIFO
threshold  in  FIFO_AW  level threshold
rdata  out  MDW  FIFO head (first-word-fall-through), zero-extended above data_size
empty  out  1  FIFO empty
full  out  1  FIFO full
level  out  FIFO_AW+1  entries held
above_th  out  1  level > threshold
overrun  out  1  1-cycle pulse
frame_err  out  1  1-cycle pulse
parity_err  out  1  1-cycle pulse
break_det  out  1  1-cycle pulse
timeout  out  1  1-cycle pulse

Behaviour:
Reset values (PRESETn low, asynchronous):
- FSM = IDLE.
- All counters 0.
- rdata = 0, level = 0, empty = 1, full = 0, above_th = 0.
- All pulses 0.

Input conditioning:
- rx passes through a 2-flop synchroniser.
- When glitch_filter_en = 1, the synchronised value also passes a GFLEN-cycle majority filter. Filtered rx resets to 1.

Tick generator:
- Counter runs 0..prescaler while en = 1 and emits a tick on wrap.
- Counter is held at 0 while en = 0.

FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE -> START on filtered rx = 0; the sample counter is cleared.
- START: at tick SC/2, a majority rx of 1 is a false start -> IDLE. Otherwise the sample counter is realigned so the next bit is centred SC ticks later.
- Each bit is sampled as the majority of ticks SC/2-1, SC/2, SC/2+1 within the bit.
- DATA: LSB first; data_size bits are captured.
- PARITY: entered only when parity_type is not none. Expected parity value:
  - odd: parity = ~^data
  - even: parity = ^data
  - stick-0: parity = 0
  - stick-1: parity = 1
- STOP: one stop bit is checked. A second stop bit is not checked; the FSM returns to IDLE and a new start edge is accepted immediately.

At the stop sample:
- If data = 0, parity bit = 0 (when present) and stop = 0: pulse break_det, push nothing, and stay in IDLE until filtered rx returns to 1.
- Otherwise push data into the FIFO.
- Pulse frame_err if stop = 0.
- Pulse parity_err if parity mismatches.
- Error pulses coincide with the push cycle.

Disable and reset mid-frame:
- en deasserted mid-frame: FSM -> IDLE next cycle, partial frame discarded, FIFO unchanged.
- Reset mid-frame: everything is cleared.

FIFO:
- Push when full: data dropped, overrun pulses; it is not re-raised until a successful push or pop.
- Push and rd in the same cycle: both succeed, including when full or empty. When empty, the pushed word bypasses to rdata on the next cycle.
- rd when empty: ignored.
- flush: clears level to 0 in one cycle and has priority over push and rd that cycle.
- Write and read pointers wrap modulo depth.
- level, empty, full and above_th are registered, consistent with each other, and update the cycle after the event.

Timeout:
- Counts bit times (SC ticks) while in IDLE with empty = 0.
- When the count reaches timeout_bits, timeout pulses once.
- Counter clears and rearms on a start edge, rd, or flush.

Test Plan:
1. PCLK 10 MHz, prescaler = 10, data_size = 8, parity none, send 8N1 0xA5 -> rdata = 0xA5, level = 1, no error pulses.
2. data_size = 9, even parity, send 0x1C3 with parity 1 -> rdata = 0x1C3, no errors. Same frame with parity 0 -> parity_err pulse, 0x1C3 still pushed.
3. Depth 16, send 17 frames 0x00..0x10 without rd -> one overrun pulse, level = 16, full = 1, rdata = 0x00. Then 16 rd pops return 0x00..0x0F and empty = 1.
4. Hold rx low for 12 bit times -> exactly one break_det, level unchanged. Normal frame 0x3C afterwards -> received correctly.
5. glitch_filter_en = 1, one-PCLK low pulse on rx -> FSM stays IDLE, no push. Same pulse with the filter off and a 2-bit-time low -> false start rejected only if rx is high at mid-start. Verify both cases.
6. timeout_bits = 4, one frame then idle -> timeout pulses once 4 bit times after stop (±1 bit). rd then idle -> no further pulse. Deassert en mid-frame -> no push, next frame received intact.

Source files
------------

// File: rtl/ef_uart_rx_fifo.sv
// UART receive engine: input synchroniser, optional glitch filter, oversampling frame FSM
// with majority-vote sampling, and a first-word-fall-through receive FIFO with status flags.
module ef_uart_rx_fifo #(
    parameter int MDW     = 9,
    parameter int SC      = 8,
    parameter int FIFO_AW = 4,
    parameter int GFLEN   = 3
) (
    input  logic               PCLK,
    input  logic               PRESETn,
    input  logic               en,
    input  logic               rx,
    input  logic [15:0]        prescaler,
    input  logic [3:0]         data_size,
    input  logic [2:0]         parity_type,
    input  logic               glitch_filter_en,
    input  logic [5:0]         timeout_bits,
    input  logic               rd,
    input  logic               flush,
    input  logic [FIFO_AW-1:0] threshold,
    output logic [MDW-1:0]     rdata,
    output logic               empty,
    output logic               full,
    output logic [FIFO_AW:0]   level,
    output logic               above_th,
    output logic               overrun,
    output logic               frame_err,
    output logic               parity_err,
    output logic               break_det,
    output logic               timeout
);
    localparam int SW    = $clog2(SC);
    localparam int BW    = $clog2(MDW + 1);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [SW-1:0]    S_LAST = SW'(SC - 1);
    localparam logic [SW-1:0]    S_V0   = SW'(SC / 2 - 1);
    localparam logic [SW-1:0]    S_V1   = SW'(SC / 2);
    localparam logic [SW-1:0]    S_V2   = SW'(SC / 2 + 1);
    localparam logic [FIFO_AW:0] LVL_FULL = (FIFO_AW + 1)'(DEPTH);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    // ---------------- input conditioning ----------------
    logic             rx_s1_q, rx_s2_q;
    logic [GFLEN-1:0] gf_q, gf_d;
    logic             filt_q, filt_d;
    logic             rx_f;
    int               gf_ones;

    always_comb begin
        gf_d    = GFLEN'({gf_q, rx_s2_q});
        gf_ones = 0;
        for (int i = 0; i < GFLEN; i++) gf_ones = gf_ones + int'(gf_d[i]);
        filt_d  = (gf_ones > GFLEN / 2);
    end

    assign rx_f = glitch_filter_en ? filt_q : rx_s2_q;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            rx_s1_q <= 1'b1;
            rx_s2_q <= 1'b1;
            gf_q    <= '1;
            filt_q  <= 1'b1;
        end else begin
            rx_s1_q <= rx;
            rx_s2_q <= rx_s1_q;
            gf_q    <= gf_d;
            filt_q  <= filt_d;
        end
    end

    // ---------------- sample tick ----------------
    logic [15:0] tick_cnt_q, tick_cnt_d;
    logic        tick;

    always_comb begin
        tick = en && (tick_cnt_q >= prescaler);
        if (!en || tick) tick_cnt_d = '0;
        else             tick_cnt_d = tick_cnt_q + 16'd1;
    end

    // ---------------- frame FSM ----------------
    state_t         state_q, state_d;
    logic [SW-1:0]  samp_q, samp_d;
    logic [BW-1:0]  bit_cnt_q, bit_cnt_d;
    logic [BW-1:0]  ds_eff, last_bit;
    logic [MDW-1:0] data_q, data_d;
    logic           par_bit_q, par_bit_d;
    logic [1:0]     v_q, v_d;
    logic           brk_wait_q, brk_wait_d;
    logic           parity_en, par_exp;
    logic           vote, vote_tick;
    logic           push_q, push_d;
    logic [MDW-1:0] push_data_q, push_data_d;
    logic           frame_err_q, frame_err_d;
    logic           parity_err_q, parity_err_d;
    logic           break_q, break_d;

    always_comb begin
        if (data_size < 4'd5 || int'(data_size) > MDW) ds_eff = BW'(MDW);
        else                                          ds_eff = BW'(data_size);
        last_bit = ds_eff - BW'(1);
    end

    always_comb begin
        parity_en = 1'b1;
        par_exp   = 1'b0;
        case (parity_type)
            3'b001:  par_exp = ~^data_q;
            3'b010:  par_exp = ^data_q;
            3'b100:  par_exp = 1'b0;
            3'b101:  par_exp = 1'b1;
            default: parity_en = 1'b0;
        endcase
    end

    // Each bit is decided on the third vote tick from the two stored samples plus the live one.
    assign vote      = (v_q[0] & v_q[1]) | (v_q[0] & rx_f) | (v_q[1] & rx_f);
    assign vote_tick = tick && (samp_q == S_V2) && (state_q != IDLE);

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (!en) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (!brk_wait_q && !rx_f) state_d = START;
                START:   if (vote_tick) state_d = vote ? IDLE : DATA;
                DATA:    if (vote_tick && bit_cnt_q == last_bit) state_d = parity_en ? PARITY : STOP;
                PARITY:  if (vote_tick) state_d = STOP;
                STOP:    if (vote_tick) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        samp_d       = samp_q;
        bit_cnt_d    = bit_cnt_q;
        data_d       = data_q;
        par_bit_d    = par_bit_q;
        v_d          = v_q;
        brk_wait_d   = brk_wait_q;
        push_d       = 1'b0;
        push_data_d  = push_data_q;
        frame_err_d  = 1'b0;
        parity_err_d = 1'b0;
        break_d      = 1'b0;
        if (!en) begin
            samp_d     = '0;
            bit_cnt_d  = '0;
            brk_wait_d = 1'b0;
        end else if (state_q == IDLE) begin
            samp_d    = '0;
            bit_cnt_d = '0;
            data_d    = '0;
            if (brk_wait_q && rx_f) brk_wait_d = 1'b0;
        end else if (tick) begin
            samp_d = (samp_q == S_LAST) ? '0 : samp_q + SW'(1);
            if (samp_q == S_V0) v_d[0] = rx_f;
            if (samp_q == S_V1) v_d[1] = rx_f;
            if (samp_q == S_V2) begin
                case (state_q)
                    DATA: begin
                        for (int i = 0; i < MDW; i++)
                            if (bit_cnt_q == BW'(i)) data_d[i] = vote;
                        bit_cnt_d = bit_cnt_q + BW'(1);
                    end
                    PARITY: par_bit_d = vote;
                    STOP: begin
                        if (data_q == '0 && (!parity_en || !par_bit_q) && !vote) begin
                            break_d    = 1'b1;
                            brk_wait_d = 1'b1;
                        end else begin
                            push_d       = 1'b1;
                            push_data_d  = data_q;
                            frame_err_d  = !vote;
                            parity_err_d = parity_en && (par_bit_q != par_exp);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // ---------------- idle timeout ----------------
    logic [SW-1:0] to_tick_q, to_tick_d;
    logic [5:0]    to_bits_q, to_bits_d;
    logic          timeout_q, timeout_d;
    logic          empty_q, start_edge;

    assign start_edge = (state_q == IDLE) && (state_d == START);

    always_comb begin
        to_tick_d = to_tick_q;
        to_bits_d = to_bits_q;
        if (start_edge || rd || flush) begin
            to_tick_d = '0;
            to_bits_d = '0;
        end else if (state_q == IDLE && !empty_q && tick) begin
            if (to_tick_q == S_LAST) begin
                to_tick_d = '0;
                if (to_bits_q != 6'h3f) to_bits_d = to_bits_q + 6'd1;
            end else begin
                to_tick_d = to_tick_q + SW'(1);
            end
        end
        // Firing only on the increment that lands on the target gives a single pulse per idle stretch.
        timeout_d = (timeout_bits != 6'd0) && (to_bits_d != to_bits_q) && (to_bits_d == timeout_bits);
    end

    // ---------------- receive FIFO ----------------
    logic [MDW-1:0]     mem_q [DEPTH];
    logic [FIFO_AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [FIFO_AW:0]   level_q, level_d;
    logic [MDW-1:0]     rdata_q, rdata_d;
    logic               empty_d, full_q, full_d, above_q, above_d;
    logic               do_push, do_rd, ovr_q, ovr_d, ovr_block_q, ovr_block_d;

    always_comb begin
        do_rd       = rd && !empty_q && !flush;
        do_push     = push_q && (!full_q || do_rd) && !flush;
        ovr_d       = push_q && full_q && !do_rd && !flush && !ovr_block_q;
        ovr_block_d = ovr_block_q;
        if (do_push || do_rd) ovr_block_d = 1'b0;
        else if (ovr_d)       ovr_block_d = 1'b1;

        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        if (flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            level_d = '0;
        end else begin
            if (do_push) wptr_d = wptr_q + FIFO_AW'(1);
            if (do_rd)   rptr_d = rptr_q + FIFO_AW'(1);
            if (do_push && !do_rd)      level_d = level_q + (FIFO_AW + 1)'(1);
            else if (do_rd && !do_push) level_d = level_q - (FIFO_AW + 1)'(1);
        end

        // The new head is the incoming word when it lands in the slot the read pointer points at.
        if (level_d == '0)                         rdata_d = '0;
        else if (do_push && rptr_d == wptr_q)      rdata_d = push_data_q;
        else                                       rdata_d = mem_q[rptr_d];

        empty_d = (level_d == '0);
        full_d  = (level_d == LVL_FULL);
        above_d = (level_d > {1'b0, threshold});
    end

    always_ff @(posedge PCLK) begin
        if (do_push) mem_q[wptr_q] <= push_data_q;
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            tick_cnt_q   <= '0;
            samp_q       <= '0;
            bit_cnt_q    <= '0;
            data_q       <= '0;
            par_bit_q    <= 1'b0;
            v_q          <= '0;
            brk_wait_q   <= 1'b0;
            push_q       <= 1'b0;
            push_data_q  <= '0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            break_q      <= 1'b0;
            to_tick_q    <= '0;
            to_bits_q    <= '0;
            timeout_q    <= 1'b0;
            wptr_q       <= '0;
            rptr_q       <= '0;
            level_q      <= '0;
            rdata_q      <= '0;
            empty_q      <= 1'b1;
            full_q       <= 1'b0;
            above_q      <= 1'b0;
            ovr_q        <= 1'b0;
            ovr_block_q  <= 1'b0;
        end else begin
            tick_cnt_q   <= tick_cnt_d;
            samp_q       <= samp_d;
            bit_cnt_q    <= bit_cnt_d;
            data_q       <= data_d;
            par_bit_q    <= par_bit_d;
            v_q          <= v_d;
            brk_wait_q   <= brk_wait_d;
            push_q       <= push_d;
            push_data_q  <= push_data_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
            break_q      <= break_d;
            to_tick_q    <= to_tick_d;
            to_bits_q    <= to_bits_d;
            timeout_q    <= timeout_d;
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            level_q      <= level_d;
            rdata_q      <= rdata_d;
            empty_q      <= empty_d;
            full_q       <= full_d;
            above_q      <= above_d;
            ovr_q        <= ovr_d;
            ovr_block_q  <= ovr_block_d;
        end
    end

    assign rdata      = rdata_q;
    assign empty      = empty_q;
    assign full       = full_q;
    assign level      = level_q;
    assign above_th   = above_q;
    assign overrun    = ovr_q;
    assign frame_err  = frame_err_q;
    assign parity_err = parity_err_q;
    assign break_det  = break_q;
    assign timeout    = timeout_q;

endmodule

// File: tb/tb_ef_uart_rx_fifo.sv
// Self-checking bench for ef_uart_rx_fifo: table-driven frame vectors plus hand-written
// sequences for overrun, flush, break, glitch, timeout and mid-frame disable.
module tb_ef_uart_rx_fifo;
    localparam int MDW = 9;
    localparam int AW  = 4;
    localparam int BIT = 11 * 8;

    logic           PCLK = 1'b0;
    logic           PRESETn = 1'b0;
    logic           en = 1'b0;
    logic           rx = 1'b1;
    logic [15:0]    prescaler = 16'd10;
    logic [3:0]     data_size = 4'd8;
    logic [2:0]     parity_type = 3'b000;
    logic           glitch_filter_en = 1'b0;
    logic [5:0]     timeout_bits = 6'd0;
    logic           rd = 1'b0;
    logic           flush = 1'b0;
    logic [AW-1:0]  threshold = 4'd3;
    logic [MDW-1:0] rdata;
    logic           empty, full, above_th, overrun, frame_err, parity_err, break_det, timeout;
    logic [AW:0]    level;

    ef_uart_rx_fifo dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .en(en), .rx(rx), .prescaler(prescaler),
        .data_size(data_size), .parity_type(parity_type), .glitch_filter_en(glitch_filter_en),
        .timeout_bits(timeout_bits), .rd(rd), .flush(flush), .threshold(threshold),
        .rdata(rdata), .empty(empty), .full(full), .level(level), .above_th(above_th),
        .overrun(overrun), .frame_err(frame_err), .parity_err(parity_err),
        .break_det(break_det), .timeout(timeout)
    );

    always #50 PCLK = ~PCLK;

    typedef struct {
        logic [8:0] d;
        logic [3:0] ds;
        logic [2:0] pt;
        logic       pflip;
        logic       stopb;
        logic [8:0] exp_d;
        logic       exp_fe;
        logic       exp_pe;
    } vec_t;

    vec_t           vecs [11];
    logic [MDW-1:0] exp_q [$];
    int n_cmp = 0, n_mis = 0;
    int n_fe = 0, n_pe = 0, n_ovr = 0, n_brk = 0, n_to = 0;
    int cyc = 0, to_cyc = 0;

    always @(posedge PCLK) cyc++;

    always @(negedge PCLK) begin
        if (frame_err)  n_fe++;
        if (parity_err) n_pe++;
        if (overrun)    n_ovr++;
        if (break_det)  n_brk++;
        if (timeout) begin
            n_to++;
            to_cyc = cyc;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge PCLK);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        step(BIT);
    endtask

    task automatic send_frame(input logic [8:0] d, input int nbits, input logic has_par,
                              input logic pbit, input logic stopb);
        send_bit(1'b0);
        for (int i = 0; i < nbits; i++) send_bit(d[i]);
        if (has_par) send_bit(pbit);
        send_bit(stopb);
        rx = 1'b1;
    endtask

    task automatic pop_check(input string name);
        logic [MDW-1:0] e;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_mis++;
            $display("FAIL %s: scoreboard empty, rdata 0x%0h", name, rdata);
        end else begin
            e = exp_q.pop_front();
            check(name, rdata, e);
        end
        rd = 1'b1;
        step(1);
        rd = 1'b0;
    endtask

    function automatic int eff_ds(input logic [3:0] ds);
        return (ds < 4'd5 || ds > 4'd9) ? 9 : int'(ds);
    endfunction

    // Returns {parity present, parity bit} for the data bits actually on the wire.
    function automatic logic [1:0] model_par(input logic [8:0] d, input int n, input logic [2:0] pt);
        int ones;
        ones = 0;
        for (int i = 0; i < n; i++) ones += int'(d[i]);
        case (pt)
            3'b001:  return {1'b1, ~ones[0]};
            3'b010:  return {1'b1, ones[0]};
            3'b100:  return 2'b10;
            3'b101:  return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    initial begin
        repeat (90000) @(posedge PCLK);
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int fe0, pe0, ovr0, brk0, to0, n, dly;
        logic [1:0] p;

        vecs[0]  = '{9'h0A5, 4'd8,  3'b000, 1'b0, 1'b1, 9'h0A5, 1'b0, 1'b0};
        vecs[1]  = '{9'h1C3, 4'd9,  3'b010, 1'b0, 1'b1, 9'h1C3, 1'b0, 1'b0};
        vecs[2]  = '{9'h1C3, 4'd9,  3'b010, 1'b1, 1'b1, 9'h1C3, 1'b0, 1'b1};
        vecs[3]  = '{9'h1F5, 4'd5,  3'b001, 1'b0, 1'b1, 9'h015, 1'b0, 1'b0};
        vecs[4]  = '{9'h05A, 4'd8,  3'b100, 1'b0, 1'b1, 9'h05A, 1'b0, 1'b0};
        vecs[5]  = '{9'h05A, 4'd8,  3'b101, 1'b1, 1'b1, 9'h05A, 1'b0, 1'b1};
        vecs[6]  = '{9'h03C, 4'd7,  3'b000, 1'b0, 1'b0, 9'h03C, 1'b1, 1'b0};
        vecs[7]  = '{9'h155, 4'd3,  3'b000, 1'b0, 1'b1, 9'h155, 1'b0, 1'b0};
        vecs[8]  = '{9'h081, 4'd8,  3'b011, 1'b0, 1'b1, 9'h081, 1'b0, 1'b0};
        vecs[9]  = '{9'h02A, 4'd6,  3'b010, 1'b0, 1'b1, 9'h02A, 1'b0, 1'b0};
        vecs[10] = '{9'h0AA, 4'd15, 3'b001, 1'b0, 1'b1, 9'h0AA, 1'b0, 1'b0};

        // reset state
        step(5);
        check("reset_rdata", rdata, 0);
        check("reset_level", level, 0);
        check("reset_empty", empty, 1);
        check("reset_full", full, 0);
        check("reset_above_th", above_th, 0);
        check("reset_pulses", {overrun, frame_err, parity_err, break_det, timeout}, 0);
        PRESETn = 1'b1;
        en = 1'b1;
        step(2 * BIT);

        // table-driven frames
        for (int k = 0; k < 11; k++) begin
            data_size = vecs[k].ds;
            parity_type = vecs[k].pt;
            n = eff_ds(vecs[k].ds);
            p = model_par(vecs[k].d, n, vecs[k].pt);
            fe0 = n_fe;
            pe0 = n_pe;
            exp_q.push_back(vecs[k].exp_d);
            send_frame(vecs[k].d, n, p[1], p[0] ^ vecs[k].pflip, vecs[k].stopb);
            step(2 * BIT);
            check($sformatf("vec%0d_level", k), level, 1);
            check($sformatf("vec%0d_frame_err", k), n_fe - fe0, vecs[k].exp_fe);
            check($sformatf("vec%0d_parity_err", k), n_pe - pe0, vecs[k].exp_pe);
            pop_check($sformatf("vec%0d_rdata", k));
            check($sformatf("vec%0d_empty_after_pop", k), empty, 1);
        end

        // overrun: 17 frames into a 16-deep FIFO
        data_size = 4'd8;
        parity_type = 3'b000;
        threshold = 4'd3;
        ovr0 = n_ovr;
        for (int k = 0; k < 17; k++) begin
            if (k < 16) exp_q.push_back(MDW'(k));
            send_frame(9'(k), 8, 1'b0, 1'b0, 1'b1);
            step(BIT / 2);
        end
        step(BIT);
        check("ovr_pulse_count", n_ovr - ovr0, 1);
        check("ovr_level", level, 16);
        check("ovr_full", full, 1);
        check("ovr_above_th", above_th, 1);
        for (int k = 0; k < 16; k++) pop_check($sformatf("ovr_pop%0d", k));
        check("ovr_drained_empty", empty, 1);
        check("ovr_drained_full", full, 0);
        rd = 1'b1;
        step(1);
        rd = 1'b0;
        check("rd_when_empty_level", level, 0);
        check("rd_when_empty_ovr", n_ovr - ovr0, 1);

        // flush with two entries held
        threshold = 4'd1;
        send_frame(9'h011, 8, 1'b0, 1'b0, 1'b1);
        send_frame(9'h022, 8, 1'b0, 1'b0, 1'b1);
        step(BIT);
        check("flush_pre_level", level, 2);
        check("flush_pre_above_th", above_th, 1);
        flush = 1'b1;
        step(1);
        flush = 1'b0;
        check("flush_level", level, 0);
        check("flush_empty", empty, 1);
        check("flush_above_th", above_th, 0);
        check("flush_rdata", rdata, 0);

        // break: rx low for 12 bit times
        brk0 = n_brk;
        fe0 = n_fe;
        rx = 1'b0;
        step(12 * BIT);
        rx = 1'b1;
        step(2 * BIT);
        check("break_count", n_brk - brk0, 1);
        check("break_level", level, 0);
        check("break_no_frame_err", n_fe - fe0, 0);
        exp_q.push_back(9'h03C);
        send_frame(9'h03C, 8, 1'b0, 1'b0, 1'b1);
        step(BIT);
        check("after_break_level", level, 1);
        pop_check("after_break_rdata");

        // glitch rejection with the filter on, then a short low with it off
        fe0 = n_fe;
        glitch_filter_en = 1'b1;
        rx = 1'b0;
        step(1);
        rx = 1'b1;
        step(2 * BIT);
        check("glitch_filtered_level", level, 0);
        glitch_filter_en = 1'b0;
        rx = 1'b0;
        step(BIT / 4);
        rx = 1'b1;
        step(2 * BIT);
        check("false_start_level", level, 0);
        check("false_start_no_frame_err", n_fe - fe0, 0);
        exp_q.push_back(9'h0FE);
        send_frame(9'h0FE, 8, 1'b0, 1'b0, 1'b1);
        step(BIT);
        check("two_bit_low_level", level, 1);
        pop_check("two_bit_low_rdata");
        glitch_filter_en = 1'b1;
        exp_q.push_back(9'h096);
        send_frame(9'h096, 8, 1'b0, 1'b0, 1'b1);
        step(BIT);
        pop_check("filtered_frame_rdata");
        glitch_filter_en = 1'b0;

        // idle timeout
        check("no_timeout_yet", n_to, 0);
        timeout_bits = 6'd4;
        to0 = n_to;
        exp_q.push_back(9'h011);
        send_frame(9'h011, 8, 1'b0, 1'b0, 1'b1);
        dly = cyc;
        for (int w = 0; w < 8 * BIT && n_to == to0; w++) step(1);
        check("timeout_seen", n_to - to0, 1);
        check("timeout_window", ((to_cyc - dly) >= 3 * BIT) && ((to_cyc - dly) <= 5 * BIT), 1);
        step(4 * BIT);
        check("timeout_once", n_to - to0, 1);
        pop_check("timeout_frame_rdata");
        step(8 * BIT);
        check("timeout_no_rearm_when_empty", n_to - to0, 1);

        // disable mid-frame
        fe0 = n_fe;
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        en = 1'b0;
        step(5);
        rx = 1'b1;
        step(BIT);
        en = 1'b1;
        step(2 * BIT);
        check("disable_level", level, 0);
        check("disable_no_frame_err", n_fe - fe0, 0);
        exp_q.push_back(9'h05A);
        send_frame(9'h05A, 8, 1'b0, 1'b0, 1'b1);
        step(BIT);
        check("after_disable_level", level, 1);
        pop_check("after_disable_rdata");
        check("scoreboard_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
